// File: rtl/cmul_round_sat.sv
// Rescales full-precision complex-multiplier products by the twiddle fraction bits.
// Results are rounded half-up, saturated to output width, and passed through a 2-stage elastic valid/ready pipe.
module cmul_round_sat #(
  parameter int IN_WIDTH  = 38,
  parameter int OUT_WIDTH = 21,
  parameter int SHIFT     = 15,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IN_WIDTH-1:0]  in_r,
  input  logic [IN_WIDTH-1:0]  in_i,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] out_r,
  output logic [OUT_WIDTH-1:0] out_i,
  output logic                 out_last,
  output logic                 sat_flag,
  input  logic                 sat_clr,
  output logic [CNT_WIDTH-1:0] sat_count
);

  localparam int HS = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic signed [IN_WIDTH:0] HALF =
    (SHIFT > 0) ? ((IN_WIDTH+1)'(1) << HS) : '0;
  localparam logic signed [IN_WIDTH:0] MAXV =
    {{(IN_WIDTH+2-OUT_WIDTH){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [IN_WIDTH:0] MINV = ~MAXV;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  // One extra bit of headroom so the rounding offset can never overflow.
  function automatic logic signed [IN_WIDTH:0] round_f(input logic signed [IN_WIDTH-1:0] x);
    logic signed [IN_WIDTH:0] ext;
    ext = {x[IN_WIDTH-1], x};
    return (ext + HALF) >>> SHIFT;
  endfunction

  // Returns {clamped, value}.
  function automatic logic [OUT_WIDTH:0] sat_f(input logic signed [IN_WIDTH:0] x);
    if (x > MAXV)      return {1'b1, MAXV[OUT_WIDTH-1:0]};
    else if (x < MINV) return {1'b1, MINV[OUT_WIDTH-1:0]};
    else               return {1'b0, x[OUT_WIDTH-1:0]};
  endfunction

  logic signed [IN_WIDTH:0]  r1_r_p1, r1_i_p1;
  logic                      last_p1, vld_p1;
  logic signed [OUT_WIDTH-1:0] out_r_p2, out_i_p2;
  logic                      last_p2, vld_p2;
  logic [OUT_WIDTH:0]        sr, si;
  logic                      ld_p1, ld_p2, sat_ev;
  logic                      flag_q;
  logic [CNT_WIDTH-1:0]      cnt_q;

  assign ld_p2    = !vld_p2 || out_ready;
  assign ld_p1    = !vld_p1 || ld_p2;
  assign in_ready = rst_n && ld_p1;

  assign sr     = sat_f(r1_r_p1);
  assign si     = sat_f(r1_i_p1);
  assign sat_ev = ld_p2 && vld_p1 && (sr[OUT_WIDTH] || si[OUT_WIDTH]);

  // Stage 1: round
  always_ff @(posedge clk) begin
    if (!rst_n)     vld_p1 <= 1'b0;
    else if (ld_p1) vld_p1 <= in_valid;
  end

  always_ff @(posedge clk) begin
    if (in_valid && in_ready) begin
      r1_r_p1 <= round_f(in_r);
      r1_i_p1 <= round_f(in_i);
      last_p1 <= in_last;
    end
  end

  // Stage 2: saturate
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p2   <= 1'b0;
      out_r_p2 <= '0;
      out_i_p2 <= '0;
      last_p2  <= 1'b0;
    end else if (ld_p2) begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        out_r_p2 <= sr[OUT_WIDTH-1:0];
        out_i_p2 <= si[OUT_WIDTH-1:0];
        last_p2  <= last_p1;
      end
    end
  end

  // A coincident event beats the clear so that no saturation goes unreported.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      flag_q <= 1'b0;
      cnt_q  <= '0;
    end else if (sat_clr) begin
      flag_q <= sat_ev;
      cnt_q  <= sat_ev ? CNT_ONE : '0;
    end else if (sat_ev) begin
      flag_q <= 1'b1;
      if (cnt_q != '1) cnt_q <= cnt_q + CNT_ONE;
    end
  end

  assign out_valid = vld_p2;
  assign out_r     = out_r_p2;
  assign out_i     = out_i_p2;
  assign out_last  = last_p2;
  assign sat_flag  = flag_q;
  assign sat_count = cnt_q;

endmodule

// File: tb/tb_cmul_round_sat.sv
// Directed bench for cmul_round_sat: default Q1.15 build plus a SHIFT=0 build.
module tb_cmul_round_sat;
  localparam int IW = 38, OW = 21, CW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, in_valid, in_last, out_ready, sat_clr;
  logic signed [IW-1:0] in_r, in_i;
  logic in_ready, out_valid, out_last, sat_flag;
  logic signed [OW-1:0] out_r, out_i;
  logic [CW-1:0] sat_count;

  logic in_valid1, in_last1, in_ready1, out_valid1, out_last1, sat_flag1;
  logic signed [21:0] in_r1, in_i1;
  logic signed [20:0] out_r1, out_i1;
  logic [15:0] sat_count1;

  cmul_round_sat #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .SHIFT(15), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_r(in_r), .in_i(in_i), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_r(out_r), .out_i(out_i), .out_last(out_last),
    .sat_flag(sat_flag), .sat_clr(sat_clr), .sat_count(sat_count));

  cmul_round_sat #(.IN_WIDTH(22), .OUT_WIDTH(21), .SHIFT(0), .CNT_WIDTH(16)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .in_r(in_r1), .in_i(in_i1), .in_last(in_last1), .out_valid(out_valid1),
    .out_ready(1'b1), .out_r(out_r1), .out_i(out_i1), .out_last(out_last1),
    .sat_flag(sat_flag1), .sat_clr(1'b0), .sat_count(sat_count1));

  int checks = 0, errors = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  typedef struct {
    longint r; longint i; longint er; longint ei; bit ef; int ec;
  } vec_t;
  vec_t tbl[7];

  int got[$];
  int sent;
  bit stall_prev;
  logic signed [OW-1:0] held;
  longint p35, n36;
  longint f_in[4];
  longint f_exp[4];

  initial begin
    p35 = longint'(1) <<< 35;
    n36 = -(longint'(1) <<< 36);
    tbl[0] = '{49152, 0, 2, 0, 0, 0};
    tbl[1] = '{16384, 0, 1, 0, 0, 0};
    tbl[2] = '{16383, 0, 0, 0, 0, 0};
    tbl[3] = '{-16384, 0, 0, 0, 0, 0};
    tbl[4] = '{-16385, 0, -1, 0, 0, 0};
    tbl[5] = '{1048575 * longint'(32768), -98304, 1048575, -3, 0, 0};
    tbl[6] = '{p35, n36, 1048575, -1048576, 1, 1};

    rst_n = 0; in_valid = 0; in_last = 0; out_ready = 1; sat_clr = 0;
    in_r = '0; in_i = '0;
    in_valid1 = 0; in_last1 = 0; in_r1 = '0; in_i1 = '0;
    cyc(); cyc();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_r", out_r, 0);
    chk("rst_out_i", out_i, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_sat_flag", sat_flag, 0);
    chk("rst_sat_count", sat_count, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_in_ready_s0", in_ready1, 0);
    rst_n = 1;
    #1 chk("post_rst_in_ready", in_ready, 1);
    cyc();

    for (int n = 0; n < 7; n++) begin
      in_valid = 1; in_r = tbl[n].r[IW-1:0]; in_i = tbl[n].i[IW-1:0];
      cyc();
      in_valid = 0;
      chk("lat_not_yet", out_valid, 0);
      cyc();
      chk("vec_valid", out_valid, 1);
      chk("vec_out_r", out_r, tbl[n].er);
      chk("vec_out_i", out_i, tbl[n].ei);
      chk("vec_sat_flag", sat_flag, tbl[n].ef);
      chk("vec_sat_count", sat_count, tbl[n].ec);
    end
    cyc(); cyc();
    chk("drained", out_valid, 0);

    // Back-pressure: out_ready high one cycle in three.
    sent = 0; stall_prev = 0; held = '0;
    for (int c = 0; c < 60 && got.size() < 8; c++) begin
      out_ready = (c % 3 == 0);
      in_valid = (sent < 8);
      in_r = IW'(longint'(sent) * 32768); in_i = '0;
      #1;
      if (stall_prev) chk("bp_hold", out_r, held);
      if (sent - got.size() == 2 && !out_ready) chk("bp_in_ready_full", in_ready, 0);
      if (out_valid && out_ready) got.push_back(int'(out_r));
      if (in_valid && in_ready) sent++;
      stall_prev = out_valid && !out_ready;
      held = out_r;
      @(posedge clk); #1;
    end
    in_valid = 0; out_ready = 1;
    chk("bp_count", got.size(), 8);
    for (int k = 0; k < got.size(); k++) chk("bp_order", got[k], k);
    cyc(); cyc();

    // Counter saturation at all-ones.
    in_valid = 1; in_r = IW'(p35); in_i = '0;
    for (int k = 0; k < 70000; k++) cyc();
    in_valid = 0;
    cyc(); cyc(); cyc();
    chk("wrap_count", sat_count, 65535);
    chk("wrap_flag", sat_flag, 1);

    sat_clr = 1; cyc(); sat_clr = 0;
    chk("clr_count", sat_count, 0);
    chk("clr_flag", sat_flag, 0);

    in_valid = 1; in_r = IW'(p35); cyc();
    in_valid = 0; cyc(); cyc();
    chk("one_event", sat_count, 1);
    in_valid = 1; in_r = IW'(p35); cyc();
    in_valid = 0; sat_clr = 1; cyc(); sat_clr = 0;
    chk("clr_evt_count", sat_count, 1);
    chk("clr_evt_flag", sat_flag, 1);
    cyc();

    // Reset with both stages full.
    out_ready = 0;
    in_valid = 1; in_r = IW'(3 * 32768); in_i = IW'(7 * 32768); cyc();
    in_r = IW'(4 * 32768); cyc();
    in_valid = 0;
    #1 chk("full_in_ready", in_ready, 0);
    chk("full_out_r", out_r, 3);
    chk("full_out_i", out_i, 7);
    rst_n = 0;
    #1 chk("in_reset_in_ready", in_ready, 0);
    cyc();
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_r", out_r, 0);
    chk("mid_rst_i", out_i, 0);
    chk("mid_rst_count", sat_count, 0);
    rst_n = 1; out_ready = 1;
    cyc();
    chk("no_stale", out_valid, 0);
    in_valid = 1; in_r = IW'(5 * 32768); in_i = '0; cyc();
    in_valid = 0;
    chk("post_rst_lat1", out_valid, 0);
    cyc();
    chk("post_rst_valid", out_valid, 1);
    chk("post_rst_r", out_r, 5);

    // SHIFT=0 build with framing.
    f_in[0] = longint'(1) <<< 20; f_exp[0] = 1048575;
    f_in[1] = -5;                 f_exp[1] = -5;
    f_in[2] = 100;                f_exp[2] = 100;
    f_in[3] = -1048576;           f_exp[3] = -1048576;
    chk("s0_flag_init", sat_flag1, 0);
    for (int c = 0; c < 6; c++) begin
      in_valid1 = (c < 4);
      in_r1 = (c < 4) ? f_in[c][21:0] : '0;
      in_i1 = '0;
      in_last1 = (c == 3);
      if (c >= 2) begin
        chk("s0_valid", out_valid1, 1);
        chk("s0_out_r", out_r1, f_exp[c-2]);
        chk("s0_out_i", out_i1, 0);
        chk("s0_last", out_last1, (c - 2 == 3));
      end
      cyc();
    end
    in_valid1 = 0; in_last1 = 0;
    chk("s0_sat_flag", sat_flag1, 1);
    chk("s0_sat_count", sat_count1, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/cmul_round_sat.md
Name: cmul_round_sat

Overview:
- Downstream stage of the complex multiplier in the merged radix-4 DIT FFT datapath.
- Takes the full-precision products c_r/c_i (DATA_WIDTH+TWID_WIDTH+1 bits) and rescales them by the twiddle fraction bits.
- Rounds, saturates back to data width, and presents results through an elastic valid/ready pipeline with frame-last tracking and saturation monitoring.
- Output feeds the next butterfly stage.

Parameters:
- IN_WIDTH, 38, width of incoming real/imag product (DATA_WIDTH 21 + TWID_WIDTH 16 + 1).
- OUT_WIDTH, 21, width of rescaled real/imag output.
- SHIFT, 15, fraction bits removed (twiddle Q1.15); 0 = no shift, no rounding.
- CNT_WIDTH, 16, width of saturation event counter.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset, sampled on rising clk.
- in_valid  in  1  in_r/in_i/in_last valid.
- in_ready  out  1  stage can accept this cycle.
- in_r  in  IN_WIDTH  signed real product.
- in_i  in  IN_WIDTH  signed imag product.
- in_last  in  1  last sample of frame.
- out_valid  out  1  out_r/out_i/out_last valid.
- out_ready  in  1  downstream accepts.
- out_r  out  OUT_WIDTH  signed rounded/saturated real.
- out_i  out  OUT_WIDTH  signed rounded/saturated imag.
- out_last  out  1  delayed in_last.
- sat_flag  out  1  sticky: any component saturated since last clear.
- sat_clr  in  1  clears sat_flag and sat_count.
- sat_count  out  CNT_WIDTH  number of output samples with ≥1 saturated component; holds at all-ones.

Behaviour:
- Reset is synchronous and active-low on clk. When rst_n is low at a rising edge: s1_valid=0, s2_valid=0; outputs out_valid=0, out_r=0, out_i=0, out_last=0, sat_flag=0, sat_count=0. in_ready is 0 while rst_n is low.
- Reset mid-operation discards all in-flight samples; no partial output appears after release.
- Transfers: input transfer occurs when in_valid && in_ready; output transfer occurs when out_valid && out_ready. out_r/out_i/out_last are stable while out_valid && !out_ready.
- Stage 1 (round):
  - SHIFT>0: r1 = (in + 2^(SHIFT-1)) >>> SHIFT, arithmetic, computed at IN_WIDTH+1 bits so the add cannot overflow. This is round-half-up, i.e. toward +inf on ties.
  - SHIFT=0: r1 = in, sign-extended.
  - Registers r1_r, r1_i, last, s1_valid.
- Stage 2 (saturate):
  - Clamp each component to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
  - Per-component sat bit = clamp applied.
  - Registers out_r, out_i, out_last, out_valid (= s2_valid), sample_sat.
- Latency: 2 cycles from input transfer to out_valid, when unstalled.
- Throughput: 1 sample/clk when out_ready is held high.
- Elastic advance rules:
  - s2 loads when !s2_valid || out_ready.
  - s1 loads when !s1_valid || s2 loads.
  - in_ready = rst_n && (!s1_valid || s2 loads). This is combinational from out_ready; no skid buffer is required.
- Bubbles: a stage with no valid data loads its valid=0; s2_valid drops after output transfer if s1 is empty.
- Saturation monitor:
  - Updates when a sample transfers from s1 into s2 and either component saturates.
  - On that event: sat_flag<=1; sat_count<=sat_count+1 unless all-ones.
  - A sample with both components saturated counts once.
- sat_clr:
  - Clears sat_flag/sat_count on the clock edge at which it is asserted.
  - If a saturation event coincides with sat_clr, the result is sat_flag=1, sat_count=1 (the new event wins).
- Stalls: while out_valid && !out_ready, no sample is dropped or duplicated. With both stages full, in_ready=0.
- in_last: travels with its sample; no other framing logic.

Test Plan:
- Rounding, SHIFT=15, OUT_WIDTH=21, out_ready=1: in_r = 49152, 16384, 16383, -16384, -16385, in_i=0 -> out_r = 2, 1, 0, 0, -1, each 2 cycles after its input; sat_flag=0.
- Saturation: in_r=2^35, in_i=-2^36 -> out_r=1048575, out_i=-1048576; sat_flag=1; sat_count=1 (counted once).
- Back-pressure:
  - Stream 8 samples (in_r=k·32768, k=0..7) with out_ready toggling 1,0,0,1,...
  - Required: out_r sequence is exactly 0..7 in order, no drops or duplicates.
  - in_ready=0 whenever both stages are full and out_ready=0.
  - Output held stable during the stall.
- Counter wrap and clear:
  - Drive 70000 saturating samples with CNT_WIDTH=16 -> sat_count holds at 65535.
  - Pulse sat_clr with no event -> sat_count=0, sat_flag=0.
  - Pulse sat_clr together with a saturating transfer -> sat_count=1, sat_flag=1.
- Reset mid-stream: assert rst_n=0 for 1 clk with both stages full -> next edge out_valid=0, out_r=out_i=0, sat_count=0, in_ready=0 during reset; first post-reset input appears 2 cycles after acceptance.
- Framing and SHIFT=0 build (IN_WIDTH=22, OUT_WIDTH=21): in_last on the 4th of 4 samples -> out_last high only with the 4th output. in_r=2^20 -> out_r=1048575 with sat_flag=1; in_r=-5 -> out_r=-5.
